max_pool: RTL

MAX_POOL -- requirements
Module: max_pool

---
 rtl/max_pool_if.sv | 33 +++
 rtl/max_pool.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/max_pool_if.sv
`default_nettype none
// ============================================================================
// Module   : max_pool_if
// Purpose  : start/busy/done handshake plus layer-0 read and layer-1 write bus
// Revision : 1.0
// ============================================================================
interface max_pool_if #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 12
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  crd;
  logic [ADDR_WIDTH-1:0] caddr_rd;
  logic [DATA_WIDTH-1:0] cdata_rd;
  logic                  cwr;
  logic [ADDR_WIDTH-1:0] caddr_wr;
  logic [DATA_WIDTH-1:0] cdata_wr;
  logic [2:0]            csel;

  // master: the pooling engine; slave: conv stage plus the memories
  modport master (
    input  start, cdata_rd,
    output busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );

  modport slave (
    output start, cdata_rd,
    input  busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );
endinterface
`default_nettype wire

// File: rtl/max_pool.sv
`default_nettype none
// ============================================================================
// Module   : max_pool
// Purpose  : 2x2 stride-2 signed max pooling of layer-0 into layer-1 memory
// Revision : 1.0
// ============================================================================
module max_pool #(
  parameter int DATA_WIDTH  = 20,
  parameter int ADDR_WIDTH  = 12,
  parameter int IMAGE_WIDTH = 64
) (
  input wire         clk,
  input wire         reset,
  max_pool_if.master bus
);
  localparam int OUT_WIDTH = IMAGE_WIDTH / 2;
  localparam int IDX_W     = $clog2(OUT_WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OUT_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_RD   = 3'b001;
  localparam logic [2:0] CSEL_WR   = 3'b011;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      r_q, r_d;
  logic [IDX_W-1:0]      c_q, c_d;
  logic [1:0]            k_q, k_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic                  capture;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  crd_q, crd_d;
  logic                  cwr_q, cwr_d;
  logic [2:0]            csel_q, csel_d;
  logic [ADDR_WIDTH-1:0] caddr_rd_q, caddr_rd_d;
  logic [ADDR_WIDTH-1:0] caddr_wr_q, caddr_wr_d;
  logic [DATA_WIDTH-1:0] cdata_wr_q, cdata_wr_d;
  logic [ADDR_WIDTH-1:0] row, col;

  // Window sequencing; in RD cycle k the word requested at k-1 is on cdata_rd.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    max_d   = max_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RD;
          k_d     = 2'd0;
        end
      end
      RD: begin
        capture = (k_q != 2'd0);
        if (k_q == 2'd3) state_d = CAP;
        else             k_d     = k_q + 2'd1;
      end
      CAP: begin
        capture = 1'b1;
        state_d = WR;
      end
      WR: begin
        if (r_q == IDX_LAST && c_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          state_d = RD;
          k_d     = 2'd0;
          if (c_q == IDX_LAST) begin
            c_d = '0;
            r_d = r_q + IDX_ONE;
          end else begin
            c_d = c_q + IDX_ONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        r_d     = '0;
        c_d     = '0;
        k_d     = 2'd0;
      end
      default: state_d = IDLE;
    endcase

    // Element 0 always loads; later elements only win when strictly larger.
    if (capture) begin
      if (state_q == RD && k_q == 2'd1)
        max_d = bus.cdata_rd;
      else if ($signed(bus.cdata_rd) > $signed(max_q))
        max_d = bus.cdata_rd;
    end
  end

  // Outputs are registered from the next state so they are glitch-free.
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    crd_d  = (state_d == RD);
    cwr_d  = (state_d == WR);
    csel_d = CSEL_NONE;
    if (state_d == RD || state_d == CAP) csel_d = CSEL_RD;
    else if (state_d == WR)              csel_d = CSEL_WR;

    row = ADDR_WIDTH'({r_d, k_d[1]});
    col = ADDR_WIDTH'({c_d, k_d[0]});
    caddr_rd_d = crd_d ? row * ADDR_WIDTH'(IMAGE_WIDTH) + col : caddr_rd_q;
    caddr_wr_d = cwr_d ? ADDR_WIDTH'(r_d) * ADDR_WIDTH'(OUT_WIDTH) + ADDR_WIDTH'(c_d)
                       : caddr_wr_q;
    cdata_wr_d = cwr_d ? max_d : cdata_wr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      r_q        <= '0;
      c_q        <= '0;
      k_q        <= 2'd0;
      max_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crd_q      <= 1'b0;
      cwr_q      <= 1'b0;
      csel_q     <= CSEL_NONE;
      caddr_rd_q <= '0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      c_q        <= c_d;
      k_q        <= k_d;
      max_q      <= max_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      crd_q      <= crd_d;
      cwr_q      <= cwr_d;
      csel_q     <= csel_d;
      caddr_rd_q <= caddr_rd_d;
      caddr_wr_q <= caddr_wr_d;
      cdata_wr_q <= cdata_wr_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.crd      = crd_q;
  assign bus.cwr      = cwr_q;
  assign bus.csel     = csel_q;
  assign bus.caddr_rd = caddr_rd_q;
  assign bus.caddr_wr = caddr_wr_q;
  assign bus.cdata_wr = cdata_wr_q;
endmodule
`default_nettype wire
